// File: rtl/sht40_pkg.sv
// SHT40 bus constants and responder state encoding shared by the
// responder and its CRC helper.
package sht40_pkg;

  localparam logic [6:0] SHT40_ADDR       = 7'h44;
  localparam logic [7:0] SHT40_MEAS_CMD   = 8'hFD;
  localparam logic [7:0] SHT40_SERIAL_CMD = 8'h89;
  localparam logic [7:0] CRC_POLY         = 8'h31;
  localparam logic [7:0] CRC_INIT         = 8'hFF;
  localparam logic [2:0] READ_BYTES       = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    RX_CMD,
    ACK_CMD,
    TX_BYTE,
    RX_MACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/sht40_crc8.sv
// Sensirion CRC-8 (poly 0x31, init 0xFF) over one 16-bit word,
// processed MSB first, purely combinational.
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [15:0] data,
  output logic [7:0]  crc
);

  always_comb begin
    crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i])
        crc = {crc[6:0], 1'b0} ^ CRC_POLY;
      else
        crc = {crc[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/sht40_responder.sv
// I2C target emulating an SHT40: measure command, 6-byte readout with CRC.
// Define SHT40_SERIAL_CMD_EN to also answer the 0x89 serial-number command.
module sht40_responder
  import sht40_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR   = SHT40_ADDR,
  parameter logic [7:0]  MEAS_CMD   = SHT40_MEAS_CMD,
  parameter logic [31:0] SERIAL_NUM = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_word,
  input  logic [15:0] hum_word,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        busy
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;

  state_t     state, state_n;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic [7:0] tx_reg;
  logic [2:0] byte_idx;
  logic       mack;
  logic [15:0] t_word, h_word;
  logic       pending, sent;

  logic       byte_done, rd, addr_ack;
  logic       meas_hit, ser_hit, cmd_ok;
  logic [7:0] crc_t, crc_h, tx_sel;
  logic       oe_n, load_tx, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_done = (bit_cnt == 4'd8);
  assign rd        = shreg[0];
  assign addr_ack  = (shreg[7:1] == I2C_ADDR) & (~rd | pending);
  assign meas_hit  = (shreg == MEAS_CMD);
`ifdef SHT40_SERIAL_CMD_EN
  assign ser_hit   = (shreg == SHT40_SERIAL_CMD);
`else
  assign ser_hit   = 1'b0;
`endif
  assign cmd_ok    = meas_hit | ser_hit;

  sht40_crc8 u_crc_t (.data(t_word), .crc(crc_t));
  sht40_crc8 u_crc_h (.data(h_word), .crc(crc_h));

  always_comb begin
    case (byte_idx)
      3'd0:    tx_sel = t_word[15:8];
      3'd1:    tx_sel = t_word[7:0];
      3'd2:    tx_sel = crc_t;
      3'd3:    tx_sel = h_word[15:8];
      3'd4:    tx_sel = h_word[7:0];
      3'd5:    tx_sel = crc_h;
      default: tx_sel = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (stop_det)
      state_n = IDLE;
    else if (start_det)
      state_n = ADDR;
    else if (scl_fall) begin
      unique case (state)
        ADDR:     if (byte_done) state_n = addr_ack ? ACK_ADDR : IGNORE;
        ACK_ADDR: state_n = rd ? TX_BYTE : RX_CMD;
        RX_CMD:   if (byte_done) state_n = cmd_ok ? ACK_CMD : IGNORE;
        ACK_CMD:  state_n = IGNORE;
        TX_BYTE:  if (byte_done) state_n = RX_MACK;
        RX_MACK:  if (bit_cnt[0]) state_n = mack ? IGNORE : TX_BYTE;
        default:  state_n = state;
      endcase
    end
  end

  // SDA only ever changes while SCL is low, except when a START/STOP frees it
  always_comb begin
    oe_n    = sda_oe;
    load_tx = 1'b0;
    accept  = 1'b0;
    if (stop_det || start_det)
      oe_n = 1'b0;
    else if (scl_fall) begin
      unique case (state)
        ADDR:     if (byte_done) oe_n = addr_ack;
        ACK_ADDR: begin
          oe_n    = rd ? ~tx_sel[7] : 1'b0;
          load_tx = rd;
        end
        RX_CMD:   if (byte_done) begin
          oe_n   = cmd_ok;
          accept = cmd_ok;
        end
        TX_BYTE:  oe_n = byte_done ? 1'b0 : ~tx_reg[6];
        RX_MACK:  if (bit_cnt[0]) begin
          oe_n    = mack ? 1'b0 : ~tx_sel[7];
          load_tx = ~mack;
        end
        default:  oe_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_oe    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      busy      <= 1'b0;
      shreg     <= 8'h00;
      bit_cnt   <= 4'd0;
      tx_reg    <= 8'h00;
      byte_idx  <= 3'd0;
      mack      <= 1'b0;
      t_word    <= 16'h0000;
      h_word    <= 16'h0000;
      pending   <= 1'b0;
      sent      <= 1'b0;
    end else begin
      sda_oe    <= oe_n;
      cmd_valid <= accept;

      if (start_det || state_n != state)
        bit_cnt <= 4'd0;
      else if (scl_rise &&
               state inside {ADDR, RX_CMD, TX_BYTE, RX_MACK})
        bit_cnt <= bit_cnt + 4'd1;

      if (scl_rise && state inside {ADDR, RX_CMD})
        shreg <= {shreg[6:0], sda_s};
      if (scl_rise && state == RX_MACK)
        mack <= sda_s;

      if (load_tx) begin
        tx_reg   <= tx_sel;
        byte_idx <= (byte_idx == READ_BYTES) ? byte_idx
                                             : byte_idx + 3'd1;
      end else if (scl_fall && state == TX_BYTE && !byte_done)
        tx_reg <= {tx_reg[6:0], 1'b1};

      if (scl_fall && state == TX_BYTE && byte_done)
        sent <= 1'b1;
      if (scl_fall && state == ADDR && byte_done && addr_ack)
        busy <= 1'b1;

      if (accept) begin
        cmd_byte <= shreg;
        pending  <= 1'b1;
        t_word   <= ser_hit ? SERIAL_NUM[31:16] : temp_word;
        h_word   <= ser_hit ? SERIAL_NUM[15:0]  : hum_word;
      end

      // a read that moved at least one byte consumes the measurement
      if (stop_det) begin
        busy <= 1'b0;
        sent <= 1'b0;
        if (sent) pending <= 1'b0;
      end else if (start_det) begin
        busy     <= 1'b0;
        byte_idx <= 3'd0;
      end
    end
  end

endmodule

// File: doc/sht40_responder.md
SHT40_RESPONDER -- requirements
Module: sht40_responder

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h44, the 7-bit target address answered.
REQ-002 SHALL have parameter MEAS_CMD, default 8'hFD, the high-precision measure command.
REQ-003 SHALL have parameter SERIAL_NUM, default 32'h0000_0000, the serial number returned when SHT40_SERIAL_CMD_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; I2C is oversampled on it.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port scl_i, input, 1 bit: bus SCL, asynchronous.
REQ-007 SHALL have port sda_i, input, 1 bit: bus SDA, asynchronous.
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain), 0 releases it.
REQ-009 SHALL have port temp_word, input, 16 bits: raw temperature, sampled at command accept.
REQ-010 SHALL have port hum_word, input, 16 bits: raw humidity, sampled at command accept.
REQ-011 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when a supported command is ACKed.
REQ-012 SHALL have port cmd_byte, output, 8 bits: last accepted command, held until the next accept.
REQ-013 SHALL have port busy, output, 1 bit: high from an addressed START until STOP or abort.

Function
REQ-014 SHALL pass scl_i and sda_i through 2-flop synchronizers, then edge-detect on clk.
REQ-015 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-016 SHALL use states IDLE, ADDR, ACK_ADDR, RX_CMD, ACK_CMD, TX_BYTE, RX_MACK, IGNORE.
REQ-017 SHALL sample SDA on synchronized SCL rising edges and update sda_oe on SCL falling edges.
REQ-018 SHALL receive 8 address bits MSB first and ACK (sda_oe=1 for one SCL low-high-low period) only when bits[7:1]==I2C_ADDR.
REQ-019 SHALL go to IGNORE on an address mismatch, release SDA and hold it released until the next START.
REQ-020 SHALL, on write (R/W=0), receive one command byte; MEAS_CMD is ACKed, cmd_valid pulses, temp/hum are latched and pending is set.
REQ-021 SHALL NACK any unsupported command, go to IGNORE, and leave pending and cmd_byte unchanged.
REQ-022 SHALL, on read (R/W=1) with pending=0, NACK the address and go to IGNORE.
REQ-023 SHALL, on read with pending=1, transmit T_MSB, T_LSB, CRC(T), H_MSB, H_LSB, CRC(H), MSB first.
REQ-024 SHALL drive a 0 data bit as sda_oe=1 and a 1 data bit as sda_oe=0.
REQ-025 SHALL, in RX_MACK, sample the master bit: ACK loads the next byte; NACK leads to IGNORE.
REQ-026 SHALL return 8'hFF (SDA released) for any byte read after the 6th.
REQ-027 SHALL use CRC-8 with polynomial 0x31, init 0xFF, no reflection, no final XOR, over the two data bytes.
REQ-028 SHALL clear pending at the STOP ending a read in which at least one byte was transmitted.
REQ-029 SHALL treat a START in any state as a repeated START: abort the byte, set sda_oe=0, enter ADDR.
REQ-030 SHALL treat a STOP in any state as a transition to IDLE with sda_oe=0.

Reset
REQ-031 SHALL, while rst is asserted, force IDLE, sda_oe=0, cmd_valid=0, cmd_byte=8'h00, busy=0, pending=0, latched words=0, and synchronizers to 1.
REQ-032 SHALL release SDA on the first clk edge with rst high when reset is asserted mid-transfer, and ignore that transfer afterwards.

Configuration
REQ-033 SHALL, when SHT40_SERIAL_CMD_EN is defined, ACK command 8'h89, latch SERIAL_NUM[31:16] and SERIAL_NUM[15:0] in place of temp/hum, and set pending.
REQ-034 SHALL, when SHT40_SERIAL_CMD_EN is undefined, NACK 8'h89 like any unsupported command and ignore SERIAL_NUM.

Structure
REQ-035 SHALL place SHT40 constants (default address, MEAS_CMD, 8'h89, CRC poly 0x31, CRC init 0xFF, read byte count 6) in shared package sht40_pkg.
REQ-036 SHALL implement the CRC as sub-module sht40_crc8: 16-bit input, combinational 8-bit output, reused for both words.

Verification
REQ-037 SHALL cover: write 0x88 (addr 0x44 W), cmd 0xFD, temp=0xBEEF, hum=0x0000 -> both ACKed, cmd_valid one cycle, cmd_byte=0xFD.
REQ-038 SHALL cover: then read 0x89 (addr 0x44 R), 6 bytes, master NACK on the last -> BE EF 92 00 00 81, then STOP clears pending.
REQ-039 SHALL cover: read before any command -> address NACKed, sda_oe stays 0 through STOP.
REQ-040 SHALL cover: address 0x45 or cmd 0x00 -> NACK, cmd_valid stays 0, bus released.
REQ-041 SHALL cover: START issued mid-byte during a read -> sda_oe=0 within 3 clk, next address decoded correctly.
REQ-042 SHALL cover: rst pulsed during TX_BYTE -> sda_oe=0 on the next clk, all outputs at reset values; cmd 0x89 with and without SHT40_SERIAL_CMD_EN.
